// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types, counter encodings and helpers for fetch_unit
// Rev 1.0
// ============================================================================
package fetch_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_SNT   = 2'b00;
    localparam cnt_t CNT_WNT   = 2'b01;
    localparam cnt_t CNT_WT    = 2'b10;
    localparam cnt_t CNT_ST    = 2'b11;
    localparam cnt_t CNT_RESET = CNT_WNT;

    // Saturating 2-bit counter step toward the resolved outcome
    function automatic cnt_t cnt_next(input cnt_t cnt, input logic taken);
        cnt_t result;
        if (taken) begin
            result = (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end else begin
            result = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
        end
        return result;
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_btb.sv
`default_nettype none
// ============================================================================
// fetch_btb : direct-mapped branch target buffer, combinational read port,
//             one synchronous write port. Rev 1.0
// ============================================================================
module fetch_btb
    import fetch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd_pc,
    output logic            hit,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_target
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_btb_size_check
        $error("fetch_btb: BTB_ENTRIES must be a power of two and at least 2");
    end

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             unused_lsb;

    assign rd_idx     = rd_pc[IDX_W+1:2];
    assign rd_tag     = rd_pc[XLEN-1:IDX_W+2];
    assign wr_idx     = wr_pc[IDX_W+1:2];
    assign wr_tag     = wr_pc[XLEN-1:IDX_W+2];
    assign unused_lsb = ^{rd_pc[1:0], wr_pc[1:0]};

    assign hit       = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    assign rd_target = btb_target[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (wr_en) begin
            btb_valid[wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observable behind a set valid bit
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            btb_tag[wr_idx]    <= wr_tag;
            btb_target[wr_idx] <= wr_target;
        end
    end

endmodule : fetch_btb
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC register, BTB + 2-bit counter next-PC prediction,
//              EX redirect/training and redirect statistics. Rev 1.0
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter int              BHT_ENTRIES = 64,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic [15:0]     mispredict_cnt
);

    localparam int HI_W = $clog2(BHT_ENTRIES);

    if (BHT_ENTRIES < 2 || (BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) begin : g_bht_size_check
        $error("fetch_unit: BHT_ENTRIES must be a power of two and at least 2");
    end

    cnt_t bht [BHT_ENTRIES];

    logic            btb_hit;
    logic [XLEN-1:0] btb_target;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    logic [HI_W-1:0] rd_hi;
    logic [HI_W-1:0] upd_hi;
    logic            unused_upd_lsb;

    assign rd_hi          = pc[HI_W+1:2];
    assign upd_hi         = upd_pc[HI_W+1:2];
    assign unused_upd_lsb = ^upd_pc[1:0];

    fetch_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (pc),
        .hit       (btb_hit),
        .rd_target (btb_target),
        .wr_en     (upd_valid && upd_taken),
        .wr_pc     (upd_pc),
        .wr_target (upd_target)
    );

    assign pc_plus4    = pc + XLEN'(4);
    assign pred_taken  = btb_hit && bht[rd_hi][1];
    assign pred_target = pred_taken ? btb_target : pc_plus4;

    always_comb begin
        next_pc = pred_target;
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (!pc_write) begin
            next_pc = pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CNT_RESET;
            end
        end else if (upd_valid) begin
            bht[upd_hi] <= cnt_next(bht[upd_hi], upd_taken);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_cnt <= '0;
        end else if (redirect_valid && (mispredict_cnt != 16'hFFFF)) begin
            mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed + randomized bench with a behavioural predictor model
// Rev 1.0
// ============================================================================
module tb_fetch_unit;

    localparam int XLEN  = 32;
    localparam int BTB_N = 16;
    localparam int BHT_N = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            pc_write;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic [15:0]     mispredict_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Model state: BTB kept as full trained PC so tags are compared arithmetically
    logic [31:0] m_pc;
    bit          m_bv   [BTB_N];
    logic [31:0] m_bpc  [BTB_N];
    logic [31:0] m_btgt [BTB_N];
    int          m_cnt  [BHT_N];
    int          m_mis;

    fetch_unit #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_N),
        .BHT_ENTRIES (BHT_N),
        .RESET_PC    (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write       (pc_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_mis = 0;
        for (int i = 0; i < BTB_N; i++) begin
            m_bv[i]   = 1'b0;
            m_bpc[i]  = '0;
            m_btgt[i] = '0;
        end
        for (int i = 0; i < BHT_N; i++) m_cnt[i] = 1;
    endtask

    task automatic model_pred(output logic t, output logic [31:0] tgt);
        int   bi;
        int   hi;
        logic hit;
        bi  = int'((m_pc / 4) % BTB_N);
        hi  = int'((m_pc / 4) % BHT_N);
        hit = m_bv[bi] && ((m_bpc[bi] / (4 * BTB_N)) == (m_pc / (4 * BTB_N)));
        t   = hit && (m_cnt[hi] >= 2);
        tgt = t ? m_btgt[bi] : m_pc + 32'd4;
    endtask

    task automatic compare_all();
        logic        t;
        logic [31:0] tgt;
        model_pred(t, tgt);
        check("pc", pc, m_pc);
        check("pred_taken", {31'b0, pred_taken}, {31'b0, t});
        check("pred_target", pred_target, tgt);
        check("mispredict_cnt", {16'b0, mispredict_cnt}, 32'(m_mis));
    endtask

    // Apply one cycle of inputs (starting at a negedge) and check the result
    task automatic tick(input logic rv, input logic [31:0] rpc, input logic pw,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utgt);
        logic        t;
        logic [31:0] tgt;
        int          hi;
        int          bi;
        redirect_valid = rv;
        redirect_pc    = rpc;
        pc_write       = pw;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utgt;
        model_pred(t, tgt);
        if (rv) m_pc = rpc;
        else if (pw) m_pc = tgt;
        if (rv && m_mis < 65535) m_mis++;
        if (uv) begin
            hi = int'((upc / 4) % BHT_N);
            bi = int'((upc / 4) % BTB_N);
            m_cnt[hi] = ut ? ((m_cnt[hi] == 3) ? 3 : m_cnt[hi] + 1)
                           : ((m_cnt[hi] == 0) ? 0 : m_cnt[hi] - 1);
            if (ut) begin
                m_bv[bi]   = 1'b1;
                m_bpc[bi]  = upc;
                m_btgt[bi] = utgt;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic stall_upd(input logic [31:0] upc, input logic ut, input logic [31:0] utgt);
        tick(1'b0, 32'h0, 1'b0, 1'b1, upc, ut, utgt);
    endtask

    initial begin
        rst = 1'b1;
        pc_write = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compare_all();
        check("reset_pc", pc, 32'h0);
        check("reset_target", pred_target, 32'h4);

        // Free-running sequential fetch
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            check("seq_pc", pc, 32'(4 * k));
            check("seq_taken", {31'b0, pred_taken}, 32'h0);
        end

        // Train 0x20 once, then fetch it
        stall_upd(32'h20, 1'b1, 32'h100);
        tick(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("train_taken", {31'b0, pred_taken}, 32'h1);
        check("train_target", pred_target, 32'h100);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("train_next_pc", pc, 32'h100);

        // Counter saturation at 0x20
        tick(1'b1, 32'h20, 1'b0, 1'b1, 32'h20, 1'b1, 32'h100);
        stall_upd(32'h20, 1'b1, 32'h100);
        stall_upd(32'h20, 1'b1, 32'h100);
        stall_upd(32'h20, 1'b0, 32'h0);
        check("sat_wt_taken", {31'b0, pred_taken}, 32'h1);
        stall_upd(32'h20, 1'b0, 32'h0);
        stall_upd(32'h20, 1'b0, 32'h0);
        check("sat_snt_taken", {31'b0, pred_taken}, 32'h0);
        check("sat_snt_target", pred_target, 32'h24);

        // Aliasing: 0x60 evicts 0x20 from the same BTB slot
        stall_upd(32'h20, 1'b1, 32'h100);
        stall_upd(32'h60, 1'b1, 32'h200);
        check("alias_taken", {31'b0, pred_taken}, 32'h0);

        // Redirect overrides a stall; plain stall holds pc
        tick(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("redir_pc", pc, 32'h400);
        check("redir_cnt", {16'b0, mispredict_cnt}, 32'd3);
        repeat (3) begin
            tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            check("stall_pc", pc, 32'h400);
        end

        // Randomized traffic over a small address window to exercise hits and aliasing
        for (int n = 0; n < 600; n++) begin
            tick($urandom_range(0, 7) == 0,
                 32'($urandom_range(0, 255)) << 2,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1,
                 (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1,
                 32'($urandom_range(0, 255)) << 2);
        end

        // Mid-stream asynchronous reset after training 0x20
        stall_upd(32'h20, 1'b1, 32'h100);
        stall_upd(32'h20, 1'b1, 32'h100);
        tick(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("pre_rst_taken", {31'b0, pred_taken}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_cnt", {16'b0, mispredict_cnt}, 32'h0);
        check("async_rst_taken", {31'b0, pred_taken}, 32'h0);
        pc_write = 1'b1; upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1; upd_target = 32'h300;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        tick(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("post_rst_taken", {31'b0, pred_taken}, 32'h0);
        check("post_rst_target", pred_target, 32'h24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end: registered PC, direct-mapped branch target buffer, and a PC-indexed table of 2-bit saturating counters. It predicts the next fetch address in the same cycle the PC is presented. Both tables are trained by branch resolution from EX, and mispredicts are redirected from EX. It sits at the head of the pipeline, drives the instruction-memory address, and passes `pred_taken`/`pred_target` down IF/ID for later mispredict checking.

## Interface
- `XLEN`, 32, PC/address width
- `BTB_ENTRIES`, 16, BTB entries; power of two, ≥2
- `BHT_ENTRIES`, 64, counter-table entries; power of two, ≥2
- `RESET_PC`, 32'h0, PC value on reset
- `clk  in  1  clock, all state on rising edge`
- `rst  in  1  reset, asynchronous, active-high`
- `pc_write  in  1  1 = PC may advance; 0 = hold (hazard stall)`
- `redirect_valid  in  1  EX mispredict/jump correction`
- `redirect_pc  in  XLEN  corrected fetch address`
- `upd_valid  in  1  resolved conditional branch this cycle`
- `upd_pc  in  XLEN  PC of the resolved branch`
- `upd_taken  in  1  actual outcome`
- `upd_target  in  XLEN  actual taken target`
- `pc  out  XLEN  current fetch address (also instruction-memory address)`
- `pred_taken  out  1  prediction for the instruction at `pc``
- `pred_target  out  XLEN  predicted next PC (BTB target or pc+4)`
- `mispredict_cnt  out  16  count of redirects since reset, saturating at 16'hFFFF`

## Operation
- Index fields. BTB index `bi = pc[log2(BTB_ENTRIES)+1:2]`, tag = `pc[XLEN-1:log2(BTB_ENTRIES)+2]`. BHT index `hi = pc[log2(BHT_ENTRIES)+1:2]`. `pc[1:0]` is ignored.
- BTB entry: valid, tag, target.
- BHT entry: 2-bit counter. SNT=00, WNT=01, WT=10, ST=11.
- Prediction is combinational from `pc`:
  - `hit = btb_valid[bi] && btb_tag[bi] == tag`
  - `pred_taken = hit && bht[hi][1]`
  - `pred_target = pred_taken ? btb_target[bi] : pc + 4`
- `pc + 4` wraps modulo 2^XLEN.
- Next-PC priority, highest first:
  1. `redirect_valid` → `redirect_pc`
  2. `!pc_write` → hold `pc`
  3. else → `pred_target`
- `redirect_valid` overrides a stall.
- When `upd_valid` is high:
  - BHT counter at `upd_pc`'s index increments if `upd_taken`, else decrements, saturating at 11/00.
  - If `upd_taken`: the BTB entry at `upd_pc`'s index is written with valid=1, `upd_pc` tag and `upd_target`, overwriting any occupant.
  - Not-taken updates never touch the BTB.
- Updates proceed regardless of `pc_write` or `redirect_valid`.
- `mispredict_cnt` increments on each cycle with `redirect_valid=1` and saturates at 16'hFFFF.

## Timing
- Reset values: `pc=RESET_PC`, all BTB valid=0, all counters WNT (01), `mispredict_cnt=0`.
- Outputs immediately after reset: `pred_taken=0`, `pred_target=RESET_PC+4`.
- Reset asserted mid-operation clears all state asynchronously. Stall and update inputs during reset are ignored.
- Prediction has 0-cycle latency: `pred_*` are valid in the same cycle as `pc`. `pc` takes the selected next value at the next edge.
- Table writes become visible one cycle after `upd_valid`. If an update targets the entry currently being read, the prediction uses the old (pre-write) value.
- Simultaneous redirect and update for the same PC: both take effect at the same edge. The redirected fetch then sees the updated tables one cycle later, in the cycle `pc` equals the new value.
- Stalled cycles re-present the same `pc`. Predictions may still change if an update lands on that entry.

## Structure
- Package `fetch_pkg` holds:
  - counter encodings `CNT_SNT/WNT/WT/ST`
  - `CNT_RESET = CNT_WNT`
  - helper function for the saturating next-counter value
- Sub-module `fetch_btb` contains the BTB arrays, tag compare and write port; it is parametrised on `XLEN` and `BTB_ENTRIES`.
- The counter table, PC register, next-PC mux and statistics counter stay in `fetch_unit`.
- Elaboration-time check: `BTB_ENTRIES` and `BHT_ENTRIES` are powers of two.

## Test plan
- Reset, then `pc_write=1` for 4 cycles with no updates → `pc` = 0, 4, 8, 12; `pred_taken=0` throughout.
- `upd_valid` with `upd_pc=0x20`, `upd_taken=1`, `upd_target=0x100`, once → counter 01→10. When `pc` reaches 0x20: `pred_taken=1`, `pred_target=0x100`, next `pc=0x100`.
- Counter saturation at `upd_pc=0x20`:
  - three taken updates → counter 11
  - one not-taken update → 10, still predicts taken
  - two more not-taken → 00, predicts not-taken, `pred_target=0x24`
- Aliasing at `BTB_ENTRIES=16`: train 0x20 taken→0x100, then 0x60 (same index, different tag) taken→0x200 → at `pc=0x20` BTB misses, `pred_taken=0`.
- `redirect_valid=1`, `redirect_pc=0x400` while `pc_write=0` → next `pc=0x400`, `mispredict_cnt` +1. With `pc_write=0` alone → `pc` holds for every stalled cycle.
- Assert `rst` mid-stream after training → `pc=RESET_PC` immediately, BTB empty, trained PC predicts not-taken, `mispredict_cnt=0`.
